// File: rtl/axis_frame_tag_strip.sv
// axis_frame_tag_strip
//
// Purpose:
//   Strips a TAG_WIDTH-bit tag header from the front of every frame on a
//   joined byte stream. The tag is published on a registered sideband, and the
//   remaining payload bytes are forwarded as an AXI-stream frame through one
//   output register stage. A frame that ends before any payload byte arrives
//   (a runt) is dropped and flagged.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   s_axis_*        input byte stream (tdata/tvalid/tready/tlast/tuser)
//   m_axis_*        payload byte stream (tdata/tvalid/tready/tlast/tuser)
//   m_tag           last extracted tag, held until the next good header
//   m_tag_valid     one-cycle pulse when m_tag updates
//   busy            header partially received, payload in flight, or output
//                   register occupied
//   error_runt      one-cycle pulse when a runt frame is dropped
//
// States:
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_HEADER   | collecting tag bytes into the shadow register, ready always
//   ST_PAYLOAD  | forwarding payload bytes through the output register

module axis_frame_tag_strip #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,

    output logic [TAG_WIDTH-1:0]  m_tag,
    output logic                  m_tag_valid,
    output logic                  busy,
    output logic                  error_runt
);

    localparam int TAG_BYTES = TAG_WIDTH / 8;
    localparam int CNT_W     = (TAG_BYTES > 1) ? $clog2(TAG_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAG_BYTES - 1);

    localparam logic [0:0] ST_HEADER  = 1'b0;
    localparam logic [0:0] ST_PAYLOAD = 1'b1;

    logic [0:0]            state_q,     state_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [TAG_WIDTH-1:0]  shadow_q,    shadow_d;
    logic [TAG_WIDTH-1:0]  tag_q,       tag_d;
    logic                  tag_valid_q, tag_valid_d;
    logic                  runt_q,      runt_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic                  valid_q,     valid_d;
    logic                  last_q,      last_d;
    logic                  user_q,      user_d;

    logic                  ready_raw;
    logic                  accept;
    logic [TAG_WIDTH-1:0]  shadow_shifted;

    // Header bytes never enter the output register, so the header phase does
    // not depend on downstream backpressure. Ready is forced low while reset
    // is held so every output reads 0 during reset.
    always_comb begin
        ready_raw = 1'b1;
        if (state_q == ST_PAYLOAD) begin
            ready_raw = m_axis_tready | ~valid_q;
        end
    end

    assign s_axis_tready  = ready_raw & ~rst;
    assign accept         = s_axis_tvalid & s_axis_tready;

    // MSB-first shift; written as a shift/or so TAG_WIDTH = 8 elaborates too.
    assign shadow_shifted = (shadow_q << DATA_WIDTH) | TAG_WIDTH'(s_axis_tdata);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        tag_d       = tag_q;
        tag_valid_d = 1'b0;
        runt_d      = 1'b0;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        user_d      = user_q;

        // Output register drains independently of the parser state, so the
        // last beat of a frame can still be pending during the next header.
        if (m_axis_tready) begin
            valid_d = 1'b0;
        end

        if (state_q == ST_HEADER) begin
            if (accept) begin
                shadow_d = shadow_shifted;
                if (s_axis_tlast) begin
                    // Frame ended with no payload: drop it, keep old tag.
                    runt_d = 1'b1;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    tag_d       = shadow_shifted;
                    tag_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_PAYLOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else begin
            if (accept) begin
                data_d  = s_axis_tdata;
                valid_d = 1'b1;
                last_d  = s_axis_tlast;
                user_d  = s_axis_tuser;
                if (s_axis_tlast) begin
                    state_d = ST_HEADER;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HEADER;
            cnt_q       <= '0;
            shadow_q    <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            runt_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            user_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            runt_q      <= runt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            user_q      <= user_d;
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tuser  = user_q;
    assign m_tag         = tag_q;
    assign m_tag_valid   = tag_valid_q;
    assign error_runt    = runt_q;
    assign busy          = (state_q == ST_PAYLOAD) | (cnt_q != '0) | valid_q;

endmodule
